turn_scheduler: RTL and testbench
=================================

# turn_scheduler

Two-player turn controller for the quiz game datapath. Grants exclusive board access to one player at a time, accepts one move per turn, enforces a per-turn time limit, and detects end of game by win or move exhaustion. Its one-cycle `finalizar` pulse drives the game-over sequencing FSM downstream.

## Interface
- `TURN_CYCLES`, default 50: maximum cycles per turn before forced hand-over; must be ≥ 2.
- `MAX_MOVES`, default 9: accepted moves that end the game as a draw; must be ≥ 1.
- `clk` in, 1: system clock; all logic is on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: begins a new game; honoured only in IDLE or DONE.
- `req` in, 2: move request; bit p comes from player p (level, sampled each cycle).
- `win` in, 1: board logic reports that the last accepted move wins; sampled only in CHECK.
- `grant` out, 2: one-hot current player during TURN, otherwise 0.
- `move_ack` out, 1: one-cycle pulse, high for exactly the CHECK cycle.
- `timeout` out, 1: one-cycle pulse on forced hand-over.
- `finalizar` out, 1: one-cycle pulse on the first cycle in DONE.
- `winner` out, 2: one-hot winning player; 0 means draw or game not over.
- `move_count` out, $clog2(MAX_MOVES+1): moves accepted in the current game.

## Operation
- States are IDLE, TURN, CHECK and DONE. An internal `player` bit tracks whose turn it is.
- Reset puts the block in IDLE with `player`=0 and all outputs 0.
- **IDLE:** `start` moves to TURN with `player`=0, `move_count`=0, `winner`=0 and the timer loaded.
- **TURN:**
  - `grant`=onehot(player).
  - `req[player]`=1 moves to CHECK and increments `move_count`.
  - Otherwise, if the timer is 0, `timeout` pulses, `player` toggles, the timer reloads and the state stays TURN.
  - Otherwise the timer decrements.
  - `req[~player]` is ignored.
- **CHECK:** `grant`=0, `move_ack`=1, then one of:
  - `win`=1: `winner`=onehot(player), go to DONE.
  - `win`=0 and `move_count`==MAX_MOVES: go to DONE with `winner`=0.
  - Otherwise: toggle `player`, reload the timer, return to TURN.
- **DONE:** `grant`=0. `winner` and `move_count` hold. `start` begins a new game exactly as from IDLE.
- Boundary rules:
  - `start` is ignored in TURN and CHECK.
  - If `req[player]` arrives when the timer is 0, the move wins: no `timeout`.
  - `rst` at any cycle returns to the reset values on the next edge.
  - A timeout does not change `move_count`.
- Timer width is $clog2(TURN_CYCLES). Load value is TURN_CYCLES-1. `move_count` never exceeds MAX_MOVES.

## Timing
- All outputs are registered and change only on `clk` edges.
- `start` sampled at edge N gives `grant`≠0 from cycle N+1.
- `req[player]` sampled at edge N puts `move_ack`=1, `grant`=0 and the incremented `move_count` in cycle N+1. `win` must be valid during that cycle.
- From CHECK at cycle N+1:
  - Next turn: `grant` shows the other player at N+2.
  - End of game: `finalizar`=1 at N+2 only; `winner` valid from N+2.
- A turn without a request lasts exactly TURN_CYCLES cycles of `grant`. `timeout` and the new `grant` appear together in the following cycle.

## Configuration
- **`TURN_TIMEOUT_EN` defined:** timer and timeout behaviour are as above.
- **`TURN_TIMEOUT_EN` undefined:**
  - No timer is instantiated and `timeout` is tied to 0.
  - TURN waits indefinitely for `req[player]`.
  - The `TURN_CYCLES` parameter is kept but unused.

## Structure
- Package `turn_pkg` holds:
  - `turn_state_t`, a 2-bit enum {IDLE, TURN, CHECK, DONE};
  - `player_t`, 1 bit;
  - constants `GRANT_NONE`=2'b00, `P0`=2'b01, `P1`=2'b10.
- Sub-module `turn_timer` is a loadable down-counter with `load`, `en` and a `zero` flag. It is instantiated only under `TURN_TIMEOUT_EN`.

## Test plan
Use TURN_CYCLES=4 and MAX_MOVES=3 with `TURN_TIMEOUT_EN` defined.
1. Reset, then pulse `start` → all outputs 0 before `start`; `grant`=01 and `move_count`=0 the cycle after.
2. `req`=01 during P0's turn with `win`=0 → next cycle `move_ack`=1, `grant`=00, `move_count`=1; the cycle after, `grant`=10.
3. No `req` while `grant`=01 → `grant` held 4 cycles, then `timeout`=1 with `grant`=10 and `move_count` unchanged. `req`=11 arriving in the 4th cycle → move accepted, no `timeout`.
4. P1 move with `win`=1 in CHECK → `finalizar` high for one cycle; `winner`=10 and `grant`=00 held; `req` then ignored.
5. Three moves, all with `win`=0 → `finalizar` pulse, `winner`=00, `move_count`=3. `start` from DONE restarts with `move_count`=0 and `grant`=01.
6. `rst` asserted mid-TURN with `move_count`=2 → next cycle all outputs 0 and state IDLE. `req`=10 during P0's turn → no `move_ack`.

Source files
------------

// File: rtl/turn_pkg.sv
// Shared types and constants for the two-player turn scheduler.
package turn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } turn_state_t;

  typedef logic player_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] P0         = 2'b01;
  localparam logic [1:0] P1         = 2'b10;

  function automatic logic [1:0] onehot(input player_t p);
    return p ? P1 : P0;
  endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// Game-side handshake between the board/players (master) and turn_scheduler (slave).
interface turn_scheduler_if #(
  parameter int MAX_MOVES = 9
);
  localparam int MC_W = $clog2(MAX_MOVES + 1);

  logic            start;
  logic [1:0]      req;
  logic            win;
  logic [1:0]      grant;
  logic            move_ack;
  logic            timeout;
  logic            finalizar;
  logic [1:0]      winner;
  logic [MC_W-1:0] move_count;

  modport master (
    output start, req, win,
    input  grant, move_ack, timeout, finalizar, winner, move_count
  );

  modport slave (
    input  start, req, win,
    output grant, move_ack, timeout, finalizar, winner, move_count
  );
endinterface

// File: rtl/turn_timer.sv
// Loadable per-turn down-counter; zero flags that the current turn has expired.
module turn_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/turn_scheduler.sv
// Two-player turn controller: exclusive grant, one move per turn, win/draw detection.
// Define TURN_TIMEOUT_EN to enable the per-turn time limit and forced hand-over.
module turn_scheduler
  import turn_pkg::*;
#(
  parameter int TURN_CYCLES = 50,
  parameter int MAX_MOVES   = 9
) (
  input  logic              clk,
  input  logic              rst,
  turn_scheduler_if.slave   bus
);

  localparam int MC_W = $clog2(MAX_MOVES + 1);
  localparam logic [MC_W-1:0] MOVES_LAST = MC_W'(MAX_MOVES);

  if (TURN_CYCLES < 2 || MAX_MOVES < 1) begin : g_bad_cfg
    $error("turn_scheduler: TURN_CYCLES must be >= 2 and MAX_MOVES >= 1");
  end

  turn_state_t     state;
  player_t         player;
  logic [1:0]      grant_q;
  logic            move_ack_q;
  logic            timeout_q;
  logic            finalizar_q;
  logic [1:0]      winner_q;
  logic [MC_W-1:0] move_count_q;
  logic            timer_expired;

`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TURN_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TURN_CYCLES - 1);

  logic timer_load;
  logic timer_en;
  logic timer_zero;

  // Reload whenever a turn is about to begin; count down only while the
  // current player is still thinking.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state)
      IDLE, DONE: timer_load = bus.start;
      CHECK:      timer_load = 1'b1;
      TURN: begin
        if (!bus.req[player]) begin
          timer_load = timer_zero;
          timer_en   = !timer_zero;
        end
      end
      default: timer_load = 1'b0;
    endcase
  end

  turn_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .en         (timer_en),
    .load_value (TIMER_LOAD),
    .zero       (timer_zero)
  );

  assign timer_expired = timer_zero;
`else
  assign timer_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      player       <= 1'b0;
      grant_q      <= GRANT_NONE;
      move_ack_q   <= 1'b0;
      timeout_q    <= 1'b0;
      finalizar_q  <= 1'b0;
      winner_q     <= GRANT_NONE;
      move_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values, regardless of statement order.
      move_ack_q  <= 1'b0;
      timeout_q   <= 1'b0;
      finalizar_q <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state        <= TURN;
            player       <= 1'b0;
            grant_q      <= P0;
            winner_q     <= GRANT_NONE;
            move_count_q <= '0;
          end
        end

        // A request from the active player beats an expiring timer.
        TURN: begin
          if (bus.req[player]) begin
            state        <= CHECK;
            grant_q      <= GRANT_NONE;
            move_ack_q   <= 1'b1;
            move_count_q <= move_count_q + MC_W'(1);
          end else if (timer_expired) begin
            timeout_q <= 1'b1;
            player    <= ~player;
            grant_q   <= onehot(~player);
          end
        end

        CHECK: begin
          if (bus.win) begin
            state       <= DONE;
            winner_q    <= onehot(player);
            finalizar_q <= 1'b1;
          end else if (move_count_q == MOVES_LAST) begin
            state       <= DONE;
            winner_q    <= GRANT_NONE;
            finalizar_q <= 1'b1;
          end else begin
            state   <= TURN;
            player  <= ~player;
            grant_q <= onehot(~player);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.move_ack   = move_ack_q;
  assign bus.timeout    = timeout_q;
  assign bus.finalizar  = finalizar_q;
  assign bus.winner     = winner_q;
  assign bus.move_count = move_count_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with TURN_CYCLES=4, MAX_MOVES=3.
module tb_turn_scheduler;
  import turn_pkg::*;

  localparam int TURN_CYCLES = 4;
  localparam int MAX_MOVES   = 3;

`ifdef TURN_TIMEOUT_EN
  localparam logic [1:0] WIN_PLAYER = P1;
`else
  localparam logic [1:0] WIN_PLAYER = P0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  turn_scheduler_if #(.MAX_MOVES(MAX_MOVES)) bus ();

  turn_scheduler #(
    .TURN_CYCLES (TURN_CYCLES),
    .MAX_MOVES   (MAX_MOVES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] g, input logic ack,
                           input logic to, input logic fin, input logic [1:0] w,
                           input logic [7:0] mc);
    check({tag, ".grant"},      8'(bus.grant),      8'(g));
    check({tag, ".move_ack"},   8'(bus.move_ack),   8'(ack));
    check({tag, ".timeout"},    8'(bus.timeout),    8'(to));
    check({tag, ".finalizar"},  8'(bus.finalizar),  8'(fin));
    check({tag, ".winner"},     8'(bus.winner),     8'(w));
    check({tag, ".move_count"}, 8'(bus.move_count), mc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.req   = 2'b00;
    bus.win   = 1'b0;

    // 1. reset, then start
    tick(); tick();
    rst = 1'b0;
    tick();
    check_all("reset", GRANT_NONE, 0, 0, 0, GRANT_NONE, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("start", P0, 0, 0, 0, GRANT_NONE, 0);

    // 2. P0 move, no win
    bus.req = 2'b01;
    tick();
    bus.req = 2'b00;
    check_all("p0_move_check", GRANT_NONE, 1, 0, 0, GRANT_NONE, 1);
    tick();
    check_all("p1_turn", P1, 0, 0, 0, GRANT_NONE, 1);

    // P1 move, no win
    bus.req = 2'b10;
    tick();
    bus.req = 2'b00;
    check_all("p1_move_check", GRANT_NONE, 1, 0, 0, GRANT_NONE, 2);
    tick();
    check_all("p0_turn_c1", P0, 0, 0, 0, GRANT_NONE, 2);

    // 3. idle turn: forced hand-over after 4 cycles of grant
`ifdef TURN_TIMEOUT_EN
    tick(); tick(); tick();
    check_all("p0_turn_c4", P0, 0, 0, 0, GRANT_NONE, 2);
    tick();
    check_all("timeout_pulse", P1, 0, 1, 0, GRANT_NONE, 2);
    tick(); tick(); tick();
    check_all("p1_turn_c4", P1, 0, 0, 0, GRANT_NONE, 2);
`else
    tick(); tick(); tick(); tick(); tick();
    check_all("no_timeout_wait", P0, 0, 0, 0, GRANT_NONE, 2);
`endif

    // request in the last timer cycle beats the timeout; win ends the game
    bus.req = 2'b11;
    bus.win = 1'b1;
    tick();
    bus.req = 2'b00;
    check_all("last_cycle_move", GRANT_NONE, 1, 0, 0, GRANT_NONE, 3);
    tick();
    bus.win = 1'b0;
    check_all("win_finalizar", GRANT_NONE, 0, 0, 1, WIN_PLAYER, 3);

    // 4. DONE holds and ignores req
    bus.req = 2'b11;
    tick();
    check_all("done_hold1", GRANT_NONE, 0, 0, 0, WIN_PLAYER, 3);
    tick();
    bus.req = 2'b00;
    check_all("done_hold2", GRANT_NONE, 0, 0, 0, WIN_PLAYER, 3);

    // 5. restart from DONE, then a draw by move exhaustion
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("restart", P0, 0, 0, 0, GRANT_NONE, 0);
    bus.req = 2'b01;
    tick();
    bus.req   = 2'b00;
    bus.start = 1'b1;
    check_all("draw_m1", GRANT_NONE, 1, 0, 0, GRANT_NONE, 1);
    tick();
    bus.start = 1'b0;
    check_all("start_in_check_ignored", P1, 0, 0, 0, GRANT_NONE, 1);
    bus.req = 2'b10;
    tick();
    bus.req = 2'b00;
    check_all("draw_m2", GRANT_NONE, 1, 0, 0, GRANT_NONE, 2);
    tick();
    check_all("draw_p0_turn", P0, 0, 0, 0, GRANT_NONE, 2);
    bus.req = 2'b01;
    tick();
    bus.req = 2'b00;
    check_all("draw_m3", GRANT_NONE, 1, 0, 0, GRANT_NONE, 3);
    tick();
    check_all("draw_finalizar", GRANT_NONE, 0, 0, 1, GRANT_NONE, 3);
    tick();
    check_all("draw_hold", GRANT_NONE, 0, 0, 0, GRANT_NONE, 3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("restart2", P0, 0, 0, 0, GRANT_NONE, 0);

    // 6. reset mid-TURN with move_count=2
    bus.req = 2'b01;
    tick();
    bus.req = 2'b00;
    tick();
    bus.req = 2'b10;
    tick();
    bus.req = 2'b00;
    tick();
    check_all("pre_reset", P0, 0, 0, 0, GRANT_NONE, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("mid_reset", GRANT_NONE, 0, 0, 0, GRANT_NONE, 0);
    bus.req = 2'b11;
    tick();
    bus.req = 2'b00;
    check_all("idle_req_ignored", GRANT_NONE, 0, 0, 0, GRANT_NONE, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("post_reset_start", P0, 0, 0, 0, GRANT_NONE, 0);
    bus.req = 2'b10;
    tick();
    bus.req = 2'b00;
    check_all("other_req_ignored", P0, 0, 0, 0, GRANT_NONE, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
